// File: rtl/controller_sequencer_pkg.sv
// Shared SAP-1 sequencer constants: opcodes, control-word bit positions,
// the inactive control word and the one-hot T-state encodings.
`ifndef CONTROLLER_SEQUENCER_PKG_SV
`define CONTROLLER_SEQUENCER_PKG_SV

package controller_sequencer_pkg;

  localparam int RING_W = 6;
  localparam int OPC_W  = 4;
  localparam int CW_W   = 12;

  localparam logic [OPC_W-1:0] OP_LDA = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
  localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  // Control word layout, MSB first.
  localparam int CW_C_P     = 11;
  localparam int CW_E_P     = 10;
  localparam int CW_L_M_BAR = 9;
  localparam int CW_CE_BAR  = 8;
  localparam int CW_L_I_BAR = 7;
  localparam int CW_E_I_BAR = 6;
  localparam int CW_L_A_BAR = 5;
  localparam int CW_E_A     = 4;
  localparam int CW_S_U     = 3;
  localparam int CW_E_U     = 2;
  localparam int CW_L_B_BAR = 1;
  localparam int CW_L_O_BAR = 0;

  // Active-low strobes idle high, everything else idles low.
  localparam logic [CW_W-1:0] CW_INACTIVE = 12'h3E3;

  localparam logic [RING_W-1:0] T1 = 6'b000001;
  localparam logic [RING_W-1:0] T2 = 6'b000010;
  localparam logic [RING_W-1:0] T3 = 6'b000100;
  localparam logic [RING_W-1:0] T4 = 6'b001000;
  localparam logic [RING_W-1:0] T5 = 6'b010000;
  localparam logic [RING_W-1:0] T6 = 6'b100000;

endpackage

`endif

// File: rtl/controller_sequencer_ring_counter.sv
// One-hot T-state ring counter with synchronous clear, advance enable and
// recovery of any non-one-hot value to the first state.
module ring_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] t
);

  localparam logic [WIDTH-1:0] FIRST = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] t_q, t_d;
  logic             onehot;

  always_comb begin
    onehot = (t_q != '0) && ((t_q & (t_q - 1'b1)) == '0);
    t_d    = t_q;
    if (!onehot)
      t_d = FIRST;
    else if (en)
      t_d = {t_q[WIDTH-2:0], t_q[WIDTH-1]};
  end

  always_ff @(posedge clk) begin
    if (clr) t_q <= FIRST;
    else     t_q <= t_d;
  end

  assign t = t_q;

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 control unit: ring-counter T-states plus combinational decode of
// T-state and opcode into the 12-bit control word, with run gating and halt.
module controller_sequencer
  import controller_sequencer_pkg::*;
#(
  parameter int RING_WIDTH   = 6,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    CLR,
  input  logic                    RUN,
  input  logic [OPCODE_WIDTH-1:0] instruction,
  output logic [RING_WIDTH-1:0]   T,
  output logic                    C_P,
  output logic                    E_P,
  output logic                    L_M_bar,
  output logic                    CE_bar,
  output logic                    L_I_bar,
  output logic                    E_I_bar,
  output logic                    L_A_bar,
  output logic                    E_A,
  output logic                    S_U,
  output logic                    E_U,
  output logic                    L_B_bar,
  output logic                    L_O_bar,
  output logic                    HLT
);

  logic [RING_WIDTH-1:0] t;
  logic [CW_W-1:0]       cw;
  logic                  halt_q, halt_d;
  logic                  halt_set;
  logic                  ring_en;

  // The halting edge itself must not advance the ring, so T stays at T4.
  assign halt_set = RUN && !halt_q && (t == T4) && (instruction == OP_HLT);
  assign ring_en  = RUN && !halt_q && !halt_set;

  ring_counter #(.WIDTH(RING_WIDTH)) u_ring (
    .clk (CLK),
    .clr (CLR),
    .en  (ring_en),
    .t   (t)
  );

  always_comb begin
    halt_d = halt_q | halt_set;
  end

  always_ff @(posedge CLK) begin
    if (CLR) halt_q <= 1'b0;
    else     halt_q <= halt_d;
  end

  always_comb begin
    cw = CW_INACTIVE;
    if (!CLR && RUN && !halt_q) begin
      case (t)
        T1: begin
          cw[CW_E_P]     = 1'b1;
          cw[CW_L_M_BAR] = 1'b0;
        end
        T2: cw[CW_C_P] = 1'b1;
        T3: begin
          cw[CW_CE_BAR]  = 1'b0;
          cw[CW_L_I_BAR] = 1'b0;
        end
        T4: begin
          if (instruction == OP_LDA || instruction == OP_ADD || instruction == OP_SUB) begin
            cw[CW_E_I_BAR] = 1'b0;
            cw[CW_L_M_BAR] = 1'b0;
          end else if (instruction == OP_OUT) begin
            cw[CW_E_A]     = 1'b1;
            cw[CW_L_O_BAR] = 1'b0;
          end
        end
        T5: begin
          if (instruction == OP_LDA) begin
            cw[CW_CE_BAR]  = 1'b0;
            cw[CW_L_A_BAR] = 1'b0;
          end else if (instruction == OP_ADD || instruction == OP_SUB) begin
            cw[CW_CE_BAR]  = 1'b0;
            cw[CW_L_B_BAR] = 1'b0;
          end
        end
        T6: begin
          if (instruction == OP_ADD || instruction == OP_SUB) begin
            cw[CW_E_U]     = 1'b1;
            cw[CW_L_A_BAR] = 1'b0;
            cw[CW_S_U]     = (instruction == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign T       = t;
  assign C_P     = cw[CW_C_P];
  assign E_P     = cw[CW_E_P];
  assign L_M_bar = cw[CW_L_M_BAR];
  assign CE_bar  = cw[CW_CE_BAR];
  assign L_I_bar = cw[CW_L_I_BAR];
  assign E_I_bar = cw[CW_E_I_BAR];
  assign L_A_bar = cw[CW_L_A_BAR];
  assign E_A     = cw[CW_E_A];
  assign S_U     = cw[CW_S_U];
  assign E_U     = cw[CW_E_U];
  assign L_B_bar = cw[CW_L_B_BAR];
  assign L_O_bar = cw[CW_L_O_BAR];
  assign HLT     = halt_q && !CLR;

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed bench for the SAP-1 sequencer: stimulus pushes the expected
// T-state/control word/HLT per cycle, a monitor pops and compares.
module tb_controller_sequencer;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       RUN = 1'b0;
  logic [3:0] instruction = 4'h0;
  logic [5:0] T;
  logic C_P, E_P, L_M_bar, CE_bar, L_I_bar, E_I_bar, L_A_bar;
  logic E_A, S_U, E_U, L_B_bar, L_O_bar, HLT;

  controller_sequencer dut (
    .CLK(CLK), .CLR(CLR), .RUN(RUN), .instruction(instruction), .T(T),
    .C_P(C_P), .E_P(E_P), .L_M_bar(L_M_bar), .CE_bar(CE_bar),
    .L_I_bar(L_I_bar), .E_I_bar(E_I_bar), .L_A_bar(L_A_bar), .E_A(E_A),
    .S_U(S_U), .E_U(E_U), .L_B_bar(L_B_bar), .L_O_bar(L_O_bar), .HLT(HLT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [5:0] t;
    logic [11:0] cw;
    logic       hlt;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Order: C_P E_P L_M_bar CE_bar L_I_bar E_I_bar L_A_bar E_A S_U E_U L_B_bar L_O_bar
  function automatic logic [11:0] mk(input logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo);
    return {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};
  endfunction

  logic [11:0] INACT, F1, F2, F3, A4, LDA5, ADD5, ADD6, SUB6, OUT4;

  always @(negedge CLK) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [11:0] act;
      e   = sb_q.pop_front();
      act = {C_P, E_P, L_M_bar, CE_bar, L_I_bar, E_I_bar, L_A_bar, E_A, S_U, E_U, L_B_bar, L_O_bar};
      n_vec++;
      if (T !== e.t || act !== e.cw || HLT !== e.hlt) begin
        n_bad++;
        $display("FAIL %s: got T=%b cw=%b HLT=%b, want T=%b cw=%b HLT=%b",
                 e.name, T, act, HLT, e.t, e.cw, e.hlt);
      end
    end
  end

  // Drive this cycle's inputs just after the edge and record what the
  // outputs must be for the remainder of the cycle.
  task automatic vec(input string name, input logic clr, input logic run, input logic [3:0] op,
                     input logic [5:0] et, input logic [11:0] ecw, input logic ehlt);
    exp_t e;
    @(posedge CLK);
    #1;
    CLR = clr;
    RUN = run;
    instruction = op;
    e.name = name; e.t = et; e.cw = ecw; e.hlt = ehlt;
    sb_q.push_back(e);
  endtask

  task automatic fetch(input string name, input logic [3:0] op);
    vec({name, "_t1"}, 1'b0, 1'b1, op, 6'h01, F1, 1'b0);
    vec({name, "_t2"}, 1'b0, 1'b1, op, 6'h02, F2, 1'b0);
    vec({name, "_t3"}, 1'b0, 1'b1, op, 6'h04, F3, 1'b0);
  endtask

  task automatic instr(input string name, input logic [3:0] op,
                       input logic [11:0] c4, input logic [11:0] c5, input logic [11:0] c6);
    fetch(name, op);
    vec({name, "_t4"}, 1'b0, 1'b1, op, 6'h08, c4, 1'b0);
    vec({name, "_t5"}, 1'b0, 1'b1, op, 6'h10, c5, 1'b0);
    vec({name, "_t6"}, 1'b0, 1'b1, op, 6'h20, c6, 1'b0);
  endtask

  initial begin
    INACT = mk(0,0,1,1,1,1,1,0,0,0,1,1);
    F1    = mk(0,1,0,1,1,1,1,0,0,0,1,1);
    F2    = mk(1,0,1,1,1,1,1,0,0,0,1,1);
    F3    = mk(0,0,1,0,0,1,1,0,0,0,1,1);
    A4    = mk(0,0,0,1,1,0,1,0,0,0,1,1);
    LDA5  = mk(0,0,1,0,1,1,0,0,0,0,1,1);
    ADD5  = mk(0,0,1,0,1,1,1,0,0,0,0,1);
    ADD6  = mk(0,0,1,1,1,1,0,0,0,1,1,1);
    SUB6  = mk(0,0,1,1,1,1,0,0,1,1,1,1);
    OUT4  = mk(0,0,1,1,1,1,1,1,0,0,1,0);

    vec("reset", 1'b1, 1'b0, 4'h0, 6'h01, INACT, 1'b0);

    instr("lda", 4'h0, A4, LDA5, INACT);
    instr("add", 4'h1, A4, ADD5, ADD6);
    instr("sub", 4'h2, A4, ADD5, SUB6);
    instr("out", 4'hE, OUT4, INACT, INACT);
    instr("nop", 4'h7, INACT, INACT, INACT);

    // RUN dropped in T2: T holds, control word idles, resumes on return.
    vec("run_t1",      1'b0, 1'b1, 4'h0, 6'h01, F1, 1'b0);
    vec("run_off_a",   1'b0, 1'b0, 4'h0, 6'h02, INACT, 1'b0);
    vec("run_off_b",   1'b0, 1'b0, 4'h0, 6'h02, INACT, 1'b0);
    vec("run_resume",  1'b0, 1'b1, 4'h0, 6'h02, F2, 1'b0);
    vec("run_t3",      1'b0, 1'b1, 4'h0, 6'h04, F3, 1'b0);
    vec("run_t4",      1'b0, 1'b1, 4'h0, 6'h08, A4, 1'b0);
    vec("run_t5",      1'b0, 1'b1, 4'h0, 6'h10, LDA5, 1'b0);
    vec("run_t6",      1'b0, 1'b1, 4'h0, 6'h20, INACT, 1'b0);

    // Halt: freezes at T4 until a CLR edge.
    fetch("hlt", 4'hF);
    vec("hlt_t4", 1'b0, 1'b1, 4'hF, 6'h08, INACT, 1'b0);
    for (int i = 0; i < 11; i++)
      vec("hlt_frozen", 1'b0, 1'b1, 4'hF, 6'h08, INACT, 1'b1);
    vec("hlt_clr",   1'b1, 1'b1, 4'hF, 6'h08, INACT, 1'b0);
    vec("hlt_after", 1'b0, 1'b1, 4'h0, 6'h01, F1, 1'b0);
    vec("hlt_after_t2", 1'b0, 1'b1, 4'h0, 6'h02, F2, 1'b0);

    // CLR in ADD T5 abandons the instruction.
    vec("abort_t3", 1'b0, 1'b1, 4'h1, 6'h04, F3, 1'b0);
    vec("abort_t4", 1'b0, 1'b1, 4'h1, 6'h08, A4, 1'b0);
    vec("abort_t5", 1'b1, 1'b1, 4'h1, 6'h10, INACT, 1'b0);
    vec("abort_t1", 1'b0, 1'b1, 4'h1, 6'h01, F1, 1'b0);

    // Illegal ring state recovers to T1 in one edge.
    @(posedge CLK);
    #1;
    force dut.u_ring.t_q = 6'b000011;
    CLR = 1'b0; RUN = 1'b1; instruction = 4'h1;
    begin
      exp_t e;
      e.name = "illegal_state"; e.t = 6'b000011; e.cw = INACT; e.hlt = 1'b0;
      sb_q.push_back(e);
    end
    #6;
    release dut.u_ring.t_q;
    vec("illegal_recover", 1'b0, 1'b1, 4'h1, 6'h01, F1, 1'b0);
    vec("illegal_next",    1'b0, 1'b1, 4'h1, 6'h02, F2, 1'b0);

    repeat (3) @(negedge CLK);
    #1;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/controller_sequencer.md
Name: controller_sequencer

Overview:
- Control unit of the SAP-1 machine. It sequences the program counter, MAR, RAM, instruction register, accumulator, adder/subtracter, B register and output register.
- A 6-state one-hot ring counter (T1..T6) advances once per CLK. On every cycle, the current T-state and the 4-bit opcode from the instruction register are decoded into the 12-bit control word.
- Executes LDA, ADD, SUB, OUT and HLT. HLT freezes the machine until reset.

Parameters:
- RING_WIDTH, 6, number of T-states; fixed at 6 for SAP-1.
- OPCODE_WIDTH, 4, width of the instruction field from the instruction register.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- CLR  input  1  synchronous reset, active-high.
- RUN  input  1  1 = sequencer advances; 0 = hold current T-state.
- instruction  input  4  opcode nibble from the instruction register.
- T  output  6  one-hot ring-counter state; bit0 = T1.
- C_P  output  1  program counter increment (active-high).
- E_P  output  1  program counter drives bus (active-high).
- L_M_bar  output  1  MAR load (active-low).
- CE_bar  output  1  RAM drives bus (active-low).
- L_I_bar  output  1  instruction register load (active-low).
- E_I_bar  output  1  instruction register address nibble drives bus (active-low).
- L_A_bar  output  1  accumulator load (active-low).
- E_A  output  1  accumulator drives bus (active-high).
- S_U  output  1  adder/subtracter: 1 = subtract.
- E_U  output  1  adder/subtracter drives bus (active-high).
- L_B_bar  output  1  B register load (active-low).
- L_O_bar  output  1  output register load (active-low).
- HLT  output  1  machine halted.

Behaviour:

Opcodes:
- LDA = 4'h0, ADD = 4'h1, SUB = 4'h2, OUT = 4'hE, HLT = 4'hF.
- All other opcodes are NOPs: T4..T6 with all control signals inactive.

"Inactive control word":
- C_P=E_P=E_A=S_U=E_U=0.
- L_M_bar=CE_bar=L_I_bar=E_I_bar=L_A_bar=L_B_bar=L_O_bar=1.

Ring counter:
- Advance T1→T2→…→T6→T1 on each rising CLK edge when RUN=1, not halted and CLR=0. Otherwise hold.
- The counter must always be exactly one-hot. Any non-one-hot value loads T1 on the next edge.

Reset:
- CLR=1 at a rising edge sets T=6'b000001 and clears the halt flag. This overrides RUN and halted.
- While CLR=1, the control word is forced inactive combinationally and HLT=0.
- Reset mid-instruction abandons the instruction; no partial state is retained.

Control word (combinational from T and instruction; only the listed signals are active):
- T1: E_P, L_M_bar=0.
- T2: C_P.
- T3: CE_bar=0, L_I_bar=0.
- LDA: T4 E_I_bar=0, L_M_bar=0; T5 CE_bar=0, L_A_bar=0; T6 none.
- ADD: T4 E_I_bar=0, L_M_bar=0; T5 CE_bar=0, L_B_bar=0; T6 E_U, L_A_bar=0, S_U=0.
- SUB: as ADD, except S_U=1 in T6.
- OUT: T4 E_A, L_O_bar=0; T5, T6 none.
- HLT: T4, T5, T6 none.

Run gating:
- When RUN=0, the control word is forced inactive; T holds.
- When RUN returns to 1, execution resumes at the held T-state with its normal control word.

Halt:
- At a rising edge with T=T4, instruction=HLT and RUN=1, the halt flag sets.
- From the next cycle: HLT=1, T frozen at T4, control word inactive.
- Only CLR clears the halt flag.

Latency and timing:
- Every instruction takes exactly 6 cycles; fetch is T1..T3.
- Opcode is sampled combinationally in T4..T6. It must be stable from the T3 edge onward, which the instruction register guarantees.
- Bus-load signals are asserted for exactly one cycle per T-state.

Decomposition:
- Shared include, guarded with ifndef/define: opcode constants, control-word bit indices, the inactive control-word constant, and T-state one-hot constants.
- One sub-module, ring_counter: one-hot shift with synchronous active-high CLR, enable and illegal-state recovery.
- The decode is combinational logic in the top module.

Test Plan:
1. CLR=1 for 1 edge, then RUN=1 → T cycles 01,02,04,08,10,20,01. C_P=1 only in T2. Fetch control word exactly as tabulated in T1..T3.
2. instruction=4'h0 (LDA): in T4 E_I_bar=0 and L_M_bar=0, all else inactive; in T5 CE_bar=0 and L_A_bar=0; T6 inactive. Repeat with 4'h1 (ADD, T6 E_U=1, S_U=0, L_A_bar=0) and 4'h2 (SUB, T6 S_U=1).
3. instruction=4'hE (OUT): in T4 E_A=1 and L_O_bar=0; T5 and T6 inactive. instruction=4'h7 → T4..T6 inactive, counter still wraps to T1.
4. instruction=4'hF: after the T4 edge, HLT=1 and T stays 6'b001000 for 10+ cycles with the control word inactive. Raising CLR for one edge → HLT=0, T=01.
5. Drop RUN to 0 during T2 → T holds 02 and C_P=0 while RUN=0. When RUN=1 again, C_P=1 for one cycle, then T=04.
6. Assert CLR during ADD T5 → next cycle T=01, L_B_bar=1 throughout the reset cycle. Force the ring counter to 6'b000011 → T=01 after one edge.
